// File: rtl/x25519_ladder_ctrl_if.sv
// Handshake bus between the X25519 ladder sequencer (master) and the
// single-iteration ladder step (slave).
interface x25519_ladder_ctrl_if;
  logic         iter_en;
  logic [511:0] iter_xzm;
  logic [511:0] iter_xzm1;
  logic         iter_b;
  logic [263:0] iter_work_low;
  logic         iter_out_valid;
  logic [511:0] iter_xzm_in;
  logic [511:0] iter_xzm1_in;

  modport master (
    output iter_en,
    output iter_xzm,
    output iter_xzm1,
    output iter_b,
    output iter_work_low,
    input  iter_out_valid,
    input  iter_xzm_in,
    input  iter_xzm1_in
  );

  modport slave (
    input  iter_en,
    input  iter_xzm,
    input  iter_xzm1,
    input  iter_b,
    input  iter_work_low,
    output iter_out_valid,
    output iter_xzm_in,
    output iter_xzm1_in
  );
endinterface

// File: rtl/x25519_ladder_ctrl.sv
// X25519 Montgomery-ladder sequencer: latches scalar and u-coordinate, builds the
// initial projective points and walks the external ladder step from bit 254 to 0.
module x25519_ladder_ctrl #(
  parameter bit CLAMP = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [255:0]                e,
  input  logic [255:0]                work_in,
  output logic                        busy,
  output logic                        out_valid,
  output logic [511:0]                xzm_out,
  x25519_ladder_ctrl_if.master        iter
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0]   TOP_POS  = 8'd254;
  localparam logic [511:0] XZM_INIT = {256'd0, 256'd1};

  // Clamping forces a fixed top bit so the ladder length is data-independent.
  function automatic logic [255:0] clamp_scalar(input logic [255:0] s);
    logic [255:0] r;
    r      = s;
    r[2:0] = 3'b000;
    r[255] = 1'b0;
    r[254] = 1'b1;
    return r;
  endfunction

  state_t       state;
  logic [255:0] scalar;
  logic [255:0] work;
  logic [7:0]   pos;
  logic [511:0] xzm;
  logic [511:0] xzm1;
  logic         iter_en_q;
  logic         iter_b_q;
  logic [255:0] scalar_in;

  assign scalar_in = CLAMP ? clamp_scalar(e) : e;

  // The issue pulse and scalar bit are registered on the edge that enters
  // ISSUE, so iter_en is high for exactly the ISSUE cycle and iter_b already
  // holds the bit for the new position.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is reset too, because the iteration-step
    // inputs and xzm_out are driven straight from them and must read zero
    // while in reset.
    if (!rst_n) begin
      state     <= IDLE;
      scalar    <= '0;
      work      <= '0;
      pos       <= '0;
      xzm       <= '0;
      xzm1      <= '0;
      xzm_out   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      iter_en_q <= 1'b0;
      iter_b_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the two one-cycle pulses
      // default low here and are raised only by the transitions below.
      iter_en_q <= 1'b0;
      out_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (en) begin
            scalar    <= scalar_in;
            work      <= work_in;
            xzm       <= XZM_INIT;
            xzm1      <= {256'd1, work_in};
            pos       <= TOP_POS;
            busy      <= 1'b1;
            iter_en_q <= 1'b1;
            iter_b_q  <= scalar_in[TOP_POS];
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          state <= WAIT;
        end

        WAIT: begin
          if (iter.iter_out_valid) begin
            xzm  <= iter.iter_xzm_in;
            xzm1 <= iter.iter_xzm1_in;
            if (pos == 8'd0) begin
              // Result is published on entry to DONE so out_valid and the
              // busy drop share the DONE cycle.
              xzm_out   <= iter.iter_xzm_in;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else begin
              pos       <= pos - 8'd1;
              iter_en_q <= 1'b1;
              iter_b_q  <= scalar[pos - 8'd1];
              state     <= ISSUE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign iter.iter_en       = iter_en_q;
  assign iter.iter_b        = iter_b_q;
  assign iter.iter_xzm      = xzm;
  assign iter.iter_xzm1     = xzm1;
  assign iter.iter_work_low = {8'h00, work};

endmodule

// File: doc/x25519_ladder_ctrl.md
Name: x25519_ladder_ctrl

Overview:
Montgomery-ladder sequencer for X25519 scalar multiplication. It takes a 256-bit scalar and a 256-bit u-coordinate, optionally clamps the scalar, and builds the initial projective points. It then drives the single-iteration ladder step 255 times (bit 254 down to bit 0), feeding each step's outputs back into the next. It sits directly upstream of the ladder-iteration step; its final projective result (x,z) goes to the downstream inversion/normalisation stage.

Parameters:
CLAMP, 1, 1 = apply RFC 7748 clamping to the latched scalar (clear bits 2:0, clear bit 255, set bit 254); 0 = use the scalar unmodified.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  start pulse; sampled only in IDLE
e  in  256  scalar, little-endian bit order (bit 0 = LSB of byte 0)
work_in  in  256  u-coordinate (little-endian)
busy  out  1  high from the cycle after an accepted en until out_valid
out_valid  out  1  one-cycle pulse; result is valid on xzm_out
xzm_out  out  512  final point; x in [255:0], z in [511:256]
iter_en  out  1  one-cycle start pulse to the iteration step
iter_xzm  out  512  current xzm to the iteration step
iter_xzm1  out  512  current xzm1 to the iteration step
iter_b  out  1  current scalar bit
iter_work_low  out  264  {8'h0, latched work_in}
iter_out_valid  in  1  completion pulse from the iteration step
iter_xzm_in  in  512  new xzm from the iteration step
iter_xzm1_in  in  512  new xzm1 from the iteration step

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs zero: busy, out_valid, iter_en, iter_b, xzm_out, iter_xzm, iter_xzm1, iter_work_low.
  - Internal scalar, work and position registers zero.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, en=1:
  - Latch the scalar, clamped if CLAMP=1.
  - Latch work_in.
  - xzm = {256'd0, 256'd1}, i.e. x=1, z=0.
  - xzm1 = {256'd1, work_in}, i.e. x=u, z=1.
  - pos = 254 (8-bit counter).
  - busy <= 1; go to ISSUE.
- ISSUE: pulse iter_en for exactly one cycle with iter_b = scalar[pos]; iter_xzm, iter_xzm1 and iter_work_low are driven from registers; go to WAIT.
- Input stability: iter_xzm, iter_xzm1, iter_b and iter_work_low hold stable from the iter_en cycle until iter_out_valid.
- WAIT, iter_out_valid=1:
  - Capture iter_xzm_in into xzm and iter_xzm1_in into xzm1.
  - If pos==0, go to DONE.
  - Otherwise pos <= pos-1 and go to ISSUE.
- DONE (one cycle): xzm_out <= xzm, out_valid <= 1, busy <= 0, go to IDLE.
- Output hold: xzm_out holds its value until the next completed run or reset.
- Timing: with iteration latency L (iter_out_valid L cycles after iter_en) and en accepted at cycle 0:
  - Iteration i issues at cycle 1+i*(L+1), for i = 0..254.
  - out_valid at cycle 255*(L+1)+1.
- Ignored inputs:
  - en while not in IDLE; no restart, no effect.
  - iter_out_valid outside WAIT; a stale pulse after reset must not advance state.
- Exactly 255 iter_en pulses per run; bit 255 is never used.
- Reset mid-run aborts immediately; the next en restarts from pos=254 with fresh initial points.
- en in the same cycle that out_valid is asserted is ignored, because state is DONE, not IDLE.

Test Plan:
- Bench uses a behavioural iteration stub with latency L=3 that records iter_b and returns iter_xzm_in=iter_xzm+1, iter_xzm1_in=iter_xzm1.
- Init values: e=0, work_in=9, en at cycle 0 -> first iter_en at cycle 1 with iter_xzm={256'd0,256'd1}, iter_xzm1={256'd1,256'd9}, iter_work_low=264'd9.
- Clamp: CLAMP=1, e=all ones -> 255 iter_en pulses; recorded b sequence is 252 ones followed by 0,0,0.
- No clamp: CLAMP=0, e=256'h5555...55 -> b sequence is e[254],e[253],...,e[0], i.e. 1,0,1,...,1.
- Feedback/latency: stub as above, L=3 -> out_valid exactly at cycle 1021, xzm_out={256'd0,256'd256}, busy low the same cycle.
- Busy protection: en pulsed at iteration 50 -> no restart, still 255 pulses, result as above.
- Reset: rst_n=0 mid-run at iteration 100 -> all outputs 0 immediately; stale stub iter_out_valid afterwards ignored; new en -> first iter_b = clamped e[254] and a full 255-iteration run.
